// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared constants for the microcoded control sequencer
//
// Purpose: control-word bit indices and masks, opcode values, the fetch
// microwords and the sequencer state type.
// Ports: none (package).

package cpu_ctrl_pkg;

    // Control-word bit positions, MSB to LSB.
    localparam int CTRL_HLT = 15;
    localparam int CTRL_MI  = 14;
    localparam int CTRL_RI  = 13;
    localparam int CTRL_RO  = 12;
    localparam int CTRL_IO  = 11;
    localparam int CTRL_II  = 10;
    localparam int CTRL_AI  = 9;
    localparam int CTRL_AO  = 8;
    localparam int CTRL_EO  = 7;
    localparam int CTRL_SU  = 6;
    localparam int CTRL_BI  = 5;
    localparam int CTRL_OI  = 4;
    localparam int CTRL_CE  = 3;
    localparam int CTRL_CO  = 2;
    localparam int CTRL_J   = 1;
    localparam int CTRL_FI  = 0;

    // One-hot masks for building microwords.
    localparam logic [15:0] M_HLT = 16'(1) << CTRL_HLT;
    localparam logic [15:0] M_MI  = 16'(1) << CTRL_MI;
    localparam logic [15:0] M_RI  = 16'(1) << CTRL_RI;
    localparam logic [15:0] M_RO  = 16'(1) << CTRL_RO;
    localparam logic [15:0] M_IO  = 16'(1) << CTRL_IO;
    localparam logic [15:0] M_II  = 16'(1) << CTRL_II;
    localparam logic [15:0] M_AI  = 16'(1) << CTRL_AI;
    localparam logic [15:0] M_AO  = 16'(1) << CTRL_AO;
    localparam logic [15:0] M_EO  = 16'(1) << CTRL_EO;
    localparam logic [15:0] M_SU  = 16'(1) << CTRL_SU;
    localparam logic [15:0] M_BI  = 16'(1) << CTRL_BI;
    localparam logic [15:0] M_OI  = 16'(1) << CTRL_OI;
    localparam logic [15:0] M_CE  = 16'(1) << CTRL_CE;
    localparam logic [15:0] M_CO  = 16'(1) << CTRL_CO;
    localparam logic [15:0] M_J   = 16'(1) << CTRL_J;
    localparam logic [15:0] M_FI  = 16'(1) << CTRL_FI;

    // Opcodes (upper nibble of the instruction register).
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Fetch microwords shared by every opcode.
    localparam logic [15:0] UW_FETCH_T0 = M_CO | M_MI;
    localparam logic [15:0] UW_FETCH_T1 = M_RO | M_II | M_CE;

    typedef enum logic {
        SEQ_RUN  = 1'b0,
        SEQ_HALT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - decode inputs and control outputs of the sequencer
//
// Purpose: bundles the instruction/flag inputs and control-word outputs.
// master: the sequencer (consumes opcode/flags, drives ctrl/step/halted).
// slave : the datapath side (drives opcode/flags, consumes ctrl/step/halted).

interface control_sequencer_if;
    logic [3:0]  opcode;
    logic        carry_flag;
    logic        zero_flag;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    modport master (
        input  opcode, carry_flag, zero_flag,
        output ctrl, step, halted
    );

    modport slave (
        output opcode, carry_flag, zero_flag,
        input  ctrl, step, halted
    );
endinterface

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational microcode table
//
// Purpose: maps (opcode, step, flags) to the microword for that T-state and
// the index of the opcode's last active step.
// Ports:
//   i_opcode     in  4  current opcode (only used from T2 on)
//   i_step       in  3  current T-state
//   i_carry_flag in  1  carry flag for JC
//   i_zero_flag  in  1  zero flag for JZ
//   o_uword      out 16 microword for this step
//   o_last_step  out 3  last active step; the step after it is T0

module microcode_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]  i_opcode,
    input  logic [2:0]  i_step,
    input  logic        i_carry_flag,
    input  logic        i_zero_flag,
    output logic [15:0] o_uword,
    output logic [2:0]  o_last_step
);

    // Opcodes with no execute work (and not-taken jumps) still spend an idle T2,
    // so the shortest instruction ends at step 2.
    always_comb begin
        o_last_step = 3'd2;
        case (i_opcode)
            OP_LDA, OP_STA: o_last_step = 3'd3;
            OP_ADD, OP_SUB: o_last_step = 3'd4;
            default:        o_last_step = 3'd2;
        endcase
    end

    always_comb begin
        o_uword = '0;
        case (i_step)
            3'd0: o_uword = UW_FETCH_T0;
            3'd1: o_uword = UW_FETCH_T1;
            3'd2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD,
                    OP_SUB, OP_STA: o_uword = M_IO | M_MI;
                    OP_LDI:         o_uword = M_IO | M_AI;
                    OP_JMP:         o_uword = M_IO | M_J;
                    OP_JC:          o_uword = i_carry_flag ? (M_IO | M_J) : '0;
                    OP_JZ:          o_uword = i_zero_flag  ? (M_IO | M_J) : '0;
                    OP_OUT:         o_uword = M_AO | M_OI;
                    OP_HLT:         o_uword = M_HLT;
                    default:        o_uword = '0;
                endcase
            end
            3'd3: begin
                case (i_opcode)
                    OP_LDA:         o_uword = M_RO | M_AI;
                    OP_ADD, OP_SUB: o_uword = M_RO | M_BI;
                    OP_STA:         o_uword = M_AO | M_RI;
                    default:        o_uword = '0;
                endcase
            end
            3'd4: begin
                case (i_opcode)
                    OP_ADD:  o_uword = M_EO | M_AI | M_FI;
                    OP_SUB:  o_uword = M_EO | M_AI | M_FI | M_SU;
                    default: o_uword = '0;
                endcase
            end
            default: o_uword = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T-state counter, halt logic and reset masking
//
// Purpose: steps through fetch/execute T-states, stops on HLT, and drives the
// control word onto the shared bus control lines.
// Ports:
//   STEPS   param    T-states per instruction slot (5..8)
//   i_clk   in  1    system clock, rising edge
//   i_rst   in  1    synchronous active-high reset
//   bus     master   opcode/flags in; ctrl/step/halted out

module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int STEPS = 5
)
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    control_sequencer_if.master  bus
);

    localparam logic [2:0] LAST_SLOT = 3'(STEPS - 1);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    logic [2:0]  r_step;
    logic [2:0]  w_step_nxt;
    logic [15:0] w_uword;
    logic [2:0]  w_last_step;

    microcode_rom u_rom (
        .i_opcode     (bus.opcode),
        .i_step       (r_step),
        .i_carry_flag (bus.carry_flag),
        .i_zero_flag  (bus.zero_flag),
        .o_uword      (w_uword),
        .o_last_step  (w_last_step)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SEQ_RUN;
            r_step  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    // HLT is recognised from the decoded microword so the halt point always
    // coincides with the cycle that actually asserts HLT; the step freezes there.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        case (r_state)
            SEQ_RUN: begin
                if (w_uword[CTRL_HLT]) begin
                    w_state_nxt = SEQ_HALT;
                end else if (r_step == w_last_step || r_step == LAST_SLOT) begin
                    w_step_nxt = 3'd0;
                end else begin
                    w_step_nxt = r_step + 3'd1;
                end
            end
            SEQ_HALT: begin
                w_state_nxt = SEQ_HALT;
            end
            default: begin
                w_state_nxt = SEQ_RUN;
                w_step_nxt  = 3'd0;
            end
        endcase
    end

    // Reset masks the whole word so no endpoint acts during the reset edge.
    always_comb begin
        bus.ctrl = '0;
        if (!i_rst) begin
            bus.ctrl = (r_state == SEQ_HALT) ? M_HLT : w_uword;
        end
    end

    assign bus.step   = r_step;
    assign bus.halted = (r_state == SEQ_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer

module tb_control_sequencer;

    typedef struct {
        logic [15:0] ctrl;
        logic [2:0]  step;
        logic        halted;
        bit          chk_state;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_sequencer_if bus ();

    control_sequencer #(.STEPS(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycles      = 0;
    bit   m_halted    = 1'b0;

    // Bus drivers: CO, RO, IO, AO, EO.
    localparam logic [15:0] BUS_DRV = 16'h1984;

    // Number of execute cycles from T2 on; zero-step opcodes spend one idle T2.
    function automatic int exec_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 2;
            4'h2, 4'h3: return 3;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [15:0] exec_word(input logic [3:0] op, input logic c,
                                              input logic z, input int k);
        case (op)
            4'h1: return (k == 0) ? 16'h4800 : 16'h1200;
            4'h2: return (k == 0) ? 16'h4800 : (k == 1) ? 16'h1020 : 16'h0281;
            4'h3: return (k == 0) ? 16'h4800 : (k == 1) ? 16'h1020 : 16'h02C1;
            4'h4: return (k == 0) ? 16'h4800 : 16'h2100;
            4'h5: return 16'h0A00;
            4'h6: return 16'h0802;
            4'h7: return c ? 16'h0802 : 16'h0000;
            4'h8: return z ? 16'h0802 : 16'h0000;
            4'hE: return 16'h0110;
            4'hF: return 16'h8000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic drive(input logic r, input logic [3:0] op, input logic c, input logic z,
                         input logic [15:0] ec, input logic [2:0] es, input logic eh,
                         input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        bus.opcode     = op;
        bus.carry_flag = c;
        bus.zero_flag  = z;
        e.ctrl      = ec;
        e.step      = es;
        e.halted    = eh;
        e.chk_state = chk;
        sb.push_back(e);
        cycles++;
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 16'h0000, 3'd0, 1'b0, 1'b0);
        m_halted = 1'b0;
    endtask

    // Runs one instruction; abort >= 0 asserts reset during that cycle instead.
    task automatic run_instr(input logic [3:0] op, input logic c, input logic z, input int abort);
        int n;
        n = 2 + exec_len(op);
        for (int k = 0; k < n; k++) begin
            logic [15:0] w;
            logic [3:0]  o;
            logic        cc, zz;
            if (k < 2) begin
                w  = (k == 0) ? 16'h4004 : 16'h1408;
                o  = 4'($urandom);
                cc = 1'($urandom);
                zz = 1'($urandom);
            end else begin
                w  = exec_word(op, c, z, k - 2);
                o  = op;
                cc = c;
                zz = z;
            end
            if (k == abort) begin
                drive(1'b1, o, cc, zz, 16'h0000, 3'(k), 1'b0, 1'b0);
                m_halted = 1'b0;
                return;
            end
            drive(1'b0, o, cc, zz, w, 3'(k), 1'b0, 1'b1);
        end
        if (op == 4'hF) m_halted = 1'b1;
    endtask

    task automatic halt_hold(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), 16'h8000, 3'd2, 1'b1, 1'b1);
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    exp_t me;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            vectors++;
            if (bus.ctrl !== me.ctrl) begin
                miscompares++;
                $display("FAIL ctrl: got %h expected %h (t=%0t)", bus.ctrl, me.ctrl, $time);
            end
            if (me.chk_state) begin
                vectors++;
                if (bus.step !== me.step || bus.halted !== me.halted) begin
                    miscompares++;
                    $display("FAIL state: got step=%0d halted=%b expected step=%0d halted=%b (t=%0t)",
                             bus.step, bus.halted, me.step, me.halted, $time);
                end
            end
            vectors++;
            if ($countones(bus.ctrl & BUS_DRV) > 1) begin
                miscompares++;
                $display("FAIL bus_owner: ctrl=%h has multiple drivers (t=%0t)", bus.ctrl, $time);
            end
        end
    end

    initial begin
        logic [3:0] op;
        bus.opcode     = 4'h0;
        bus.carry_flag = 1'b0;
        bus.zero_flag  = 1'b0;

        reset_cycles(2);

        // Every opcode once, plus both flag cases for the conditional jumps.
        for (int o = 0; o < 16; o++)
            if (o != 15) run_instr(4'(o), 1'b0, 1'b0, -1);
        run_instr(4'h7, 1'b1, 1'b0, -1);
        run_instr(4'h7, 1'b0, 1'b1, -1);
        run_instr(4'h8, 1'b0, 1'b1, -1);
        run_instr(4'h8, 1'b1, 1'b0, -1);

        // Reset during ADD T3, then reset coinciding with HLT's T2.
        run_instr(4'h2, 1'b0, 1'b0, 3);
        run_instr(4'h3, 1'b1, 1'b1, -1);
        run_instr(4'hF, 1'b0, 1'b0, 2);
        run_instr(4'h1, 1'b0, 1'b0, -1);

        // Halt, hold 20 cycles, reset out of it.
        run_instr(4'hF, 1'b0, 1'b0, -1);
        halt_hold(20);
        reset_cycles(1);
        run_instr(4'h2, 1'b0, 1'b0, -1);

        // Random opcode stream.
        while (cycles < 1100) begin
            op = 4'($urandom);
            if ($urandom_range(0, 19) == 0)
                run_instr(op, 1'($urandom), 1'($urandom), $urandom_range(0, 1 + exec_len(op)));
            else
                run_instr(op, 1'($urandom), 1'($urandom), -1);
            if (m_halted) begin
                halt_hold($urandom_range(1, 5));
                reset_cycles(1);
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
